// File: rtl/addsub_pkg.sv
// Shared types and elaboration helpers for the serial adder-subtractor.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic bit digit_ok(input int unsigned width, input int unsigned digit);
        return (width >= 2) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/serial_digit_slice.sv
// Combinational DIGIT-bit adder slice; c_msb is the carry into the slice MSB.
module serial_digit_slice #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [DIGIT:0] total;

    always_comb begin
        total = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};
        s     = total[DIGIT-1:0];
        cout  = total[DIGIT];
        // Carry into the MSB recovered from the MSB sum bit and its operands.
        c_msb = x[DIGIT-1] ^ y[DIGIT-1] ^ total[DIGIT-1];
    end

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial two's-complement adder-subtractor, LSB-first, valid/ready on both sides.
module serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    if (!digit_ok(WIDTH, DIGIT)) begin : g_bad_digit
        $error("serial_addsub: DIGIT must divide WIDTH and WIDTH must be >= 2");
    end

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [CW-1:0]     count_q, count_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [DIGIT-1:0]  slice_s;
    logic              slice_cout;
    logic              slice_cmsb;
    logic [WIDTH-1:0]  sum_next;

    serial_digit_slice #(
        .DIGIT(DIGIT)
    ) u_slice (
        .x     (a_q[DIGIT-1:0]),
        .y     (b_q[DIGIT-1:0]),
        .cin   (carry_q),
        .s     (slice_s),
        .cout  (slice_cout),
        .c_msb (slice_cmsb)
    );

    // A single-step build has no older digits to keep in the result register.
    if (STEPS == 1) begin : g_single
        assign sum_next = slice_s;
    end else begin : g_multi
        assign sum_next = {slice_s, sum_q[WIDTH-1:DIGIT]};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        count_d = count_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub;
                    count_d = '0;
                    sum_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                sum_d   = sum_next;
                carry_d = slice_cout;
                count_d = count_q + 1'b1;
                if (count_q == LAST) begin
                    cout_d  = slice_cout;
                    ovf_d   = slice_cmsb ^ slice_cout;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            count_q <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == CALC);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule
